// File: rtl/r16_twiddle_addr_gen.sv
// Radix-16 DTFAG twiddle address sequencer with ROM-pipe valid tracking.
// Optional issue stall port is enabled by defining R16_TWG_STALL_EN.
module r16_twiddle_addr_gen #(
  parameter int STAGE_NUM = 4,
  parameter int STG_W     = 2,
  parameter int GRP_W     = 4*(STAGE_NUM-1),
  parameter int VAL_LAT   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef R16_TWG_STALL_EN
  input  logic               stall,
`endif
  output logic [GRP_W/2-1:0] rom0_addr,
  output logic [GRP_W/2-1:0] romx_addr,
  output logic               rom_en,
  output logic [STG_W-1:0]   stage_idx,
  output logic               tw_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [GRP_W-1:0]   g_q;
  logic [GRP_W-1:0]   g_d;
  logic [STG_W-1:0]   s_q;
  logic [STG_W-1:0]   s_d;
  logic [GRP_W-1:0]   cur_g;
  logic [STG_W-1:0]   cur_s;
  logic [GRP_W-1:0]   exp_e;
  logic [VAL_LAT-1:0] vpipe_q;
  logic [VAL_LAT-1:0] vpipe_d;
  logic               stall_i;
  logic               issue;
  logic               last_issue;
  logic               drained;
  logic               busy_d;
  logic               done_d;

`ifdef R16_TWG_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign tw_valid = vpipe_q[VAL_LAT-1];

  // IDLE issues the g=0,s=0 address on the same edge that accepts start.
  always_comb begin
    cur_g = g_q;
    cur_s = s_q;
    if (state_q == S_IDLE) begin
      cur_g = '0;
      cur_s = '0;
    end
  end

  // Bits shifted past GRP_W are exactly those the stage mask removes.
  assign exp_e = cur_g << {cur_s, 2'b00};

  assign last_issue = (&cur_g) &&
                      (cur_s == STG_W'(STAGE_NUM-1));

  assign vpipe_d = {vpipe_q[VAL_LAT-2:0], rom_en};
  assign drained = ~|vpipe_d;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    s_d     = s_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !done) begin
          issue   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall_i) begin
          issue = 1'b1;
          if (last_issue) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (drained) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (issue) begin
      g_d = cur_g + GRP_W'(1);
      s_d = cur_s;
      if (&cur_g) begin
        s_d = cur_s + STG_W'(1);
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      s_q     <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      vpipe_q <= vpipe_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom0_addr <= '0;
      romx_addr <= '0;
      stage_idx <= '0;
      rom_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rom_en <= issue;
      busy   <= busy_d;
      done   <= done_d;
      if (issue) begin
        rom0_addr <= exp_e[GRP_W-1:GRP_W/2];
        romx_addr <= exp_e[GRP_W/2-1:0];
        stage_idx <= cur_s;
      end
    end
  end

endmodule

// File: tb/tb_r16_twiddle_addr_gen.sv
// Scoreboard bench for r16_twiddle_addr_gen (STAGE_NUM=2 and 3 instances).
// Stall scenario is compiled only when R16_TWG_STALL_EN is defined.
module tb_r16_twiddle_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start2 = 1'b0;
  logic       start3 = 1'b0;
  logic       stall = 1'b0;
  logic [1:0] rom0_2, romx_2, stg_2;
  logic       en_2, val_2, busy_2, done_2;
  logic [3:0] rom0_3, romx_3;
  logic [1:0] stg_3;
  logic       en_3, val_3, busy_3, done_3;

  int total = 0;
  int bad = 0;

  typedef struct {
    int r0;
    int rx;
    int st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  r16_twiddle_addr_gen #(
    .STAGE_NUM(2), .STG_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef R16_TWG_STALL_EN
    .stall(stall),
`endif
    .rom0_addr(rom0_2), .romx_addr(romx_2), .rom_en(en_2),
    .stage_idx(stg_2), .tw_valid(val_2), .busy(busy_2),
    .done(done_2)
  );

  r16_twiddle_addr_gen #(
    .STAGE_NUM(3), .STG_W(2)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef R16_TWG_STALL_EN
    .stall(1'b0),
`endif
    .rom0_addr(rom0_3), .romx_addr(romx_3), .rom_en(en_3),
    .stage_idx(stg_3), .tw_valid(val_3), .busy(busy_3),
    .done(done_3)
  );

  function automatic exp_t ref_issue(int sn, int s, int g);
    exp_t r;
    int gw;
    int e;
    gw = 4*(sn-1);
    e = (g & ((1 << (4*(sn-1-s))) - 1)) << (4*s);
    e = e & ((1 << gw) - 1);
    r.r0 = e >> (gw/2);
    r.rx = e & ((1 << (gw/2)) - 1);
    r.st = s;
    return r;
  endfunction

  task automatic push_run(int sn);
    for (int s = 0; s < sn; s++)
      for (int g = 0; g < (1 << (4*(sn-1))); g++)
        sb.push_back(ref_issue(sn, s, g));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rom0_2, romx_2, stg_2, en_2, val_2, busy_2, done_2} !== '0) begin
      bad++;
      $display("FAIL reset2 got=%b want=0",
               {rom0_2, romx_2, stg_2, en_2, val_2, busy_2, done_2});
    end
    total++;
    if ({rom0_3, romx_3, stg_3, en_3, val_3, busy_3, done_3} !== '0) begin
      bad++;
      $display("FAIL reset3 got=%b want=0",
               {rom0_3, romx_3, stg_3, en_3, val_3, busy_3, done_3});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_and_valid();
    int cyc, n, first, last, done_at;
    bit re[$];
    bit ev;
    exp_t x;
    sb.delete();
    push_run(2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; n = 0; first = -1; last = -1; done_at = -1;
    while (done_at < 0 && cyc < 100) begin
      if (en_2) begin
        x = sb.pop_front();
        total++;
        if (rom0_2 !== 2'(x.r0) || romx_2 !== 2'(x.rx) ||
            stg_2 !== 2'(x.st)) begin
          bad++;
          $display("FAIL issue%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   n, rom0_2, romx_2, stg_2, x.r0, x.rx, x.st);
        end
        if (n == 6) begin
          total++;
          if (rom0_2 !== 2'd1 || romx_2 !== 2'd2) begin
            bad++;
            $display("FAIL g6_addr got=%0d/%0d want=1/2", rom0_2, romx_2);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
      ev = (re.size() >= 7) ? re[re.size()-7] : 1'b0;
      total++;
      if (val_2 !== ev) begin
        bad++;
        $display("FAIL valid_c%0d got=%b want=%b", cyc, val_2, ev);
      end
      re.push_back(en_2);
      if (done_2) begin
        done_at = cyc;
        total++;
        if (busy_2 !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done got=%b want=0", busy_2);
        end
      end
      start2 = (cyc == 10);
      cyc++;
      @(negedge clk);
    end
    start2 = 1'b0;
    total++;
    if (done_at < 0) begin
      bad++;
      $display("FAIL done_timeout got=none want=done");
    end
    total++;
    if (n !== 32 || first !== 0 || last - first !== 31) begin
      bad++;
      $display("FAIL run_issues got=%0d first=%0d last=%0d want=32/0/31",
               n, first, last);
    end
    total++;
    if (done_at - last !== 8) begin
      bad++;
      $display("FAIL done_lat got=%0d want=8", done_at - last);
    end
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_left got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      seen = done_2;
      cyc++;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_timeout got=none want=done");
    end
    start2 = 1'b1;
    @(negedge clk);
    total++;
    if (busy_2 !== 1'b0 || en_2 !== 1'b0) begin
      bad++;
      $display("FAIL start_on_done got=%b%b want=00", busy_2, en_2);
    end
    @(negedge clk);
    start2 = 1'b0;
    total++;
    if (busy_2 !== 1'b1 || en_2 !== 1'b1 || stg_2 !== 2'd0 ||
        rom0_2 !== 2'd0 || romx_2 !== 2'd0) begin
      bad++;
      $display("FAIL start_after_done got=%b%b/%0d/%0d/%0d want=11/0/0/0",
               busy_2, en_2, stg_2, rom0_2, romx_2);
    end
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      seen = done_2;
      cyc++;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_timeout2 got=none want=done");
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n, cyc;
    exp_t x;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0; cyc = 0;
    while (n < 21 && cyc < 100) begin
      if (en_2) n++;
      if (n < 21) begin
        @(negedge clk);
        cyc++;
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rom0_2, romx_2, stg_2, en_2, val_2, busy_2, done_2} !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b want=0",
               {rom0_2, romx_2, stg_2, en_2, val_2, busy_2, done_2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if ({en_2, val_2, busy_2, done_2} !== 4'b0) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=0000",
               {en_2, val_2, busy_2, done_2});
    end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      x = ref_issue(2, 0, k);
      total++;
      if (en_2 !== 1'b1 || stg_2 !== 2'(x.st) ||
          rom0_2 !== 2'(x.r0) || romx_2 !== 2'(x.rx)) begin
        bad++;
        $display("FAIL restart_g%0d got=%b/%0d/%0d/%0d want=1/%0d/%0d/%0d",
                 k, en_2, stg_2, rom0_2, romx_2, x.st, x.r0, x.rx);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exponent();
    int n, cyc;
    bit seen;
    exp_t x;
    sb.delete();
    push_run(3);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 900) begin
      if (en_3) begin
        x = sb.pop_front();
        if (x.r0 !== ref_issue(3, n / 256, n % 256).r0) x.r0 = -1;
        total++;
        if (rom0_3 !== 4'(x.r0) || romx_3 !== 4'(x.rx) ||
            stg_3 !== 2'(x.st)) begin
          bad++;
          $display("FAIL exp_issue%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   n, rom0_3, romx_3, stg_3, x.r0, x.rx, x.st);
        end
        if (n == 256 + 'h23) begin
          total++;
          if (rom0_3 !== 4'd3 || romx_3 !== 4'd0 || stg_3 !== 2'd1) begin
            bad++;
            $display("FAIL s1_g23 got=%0d/%0d/%0d want=3/0/1",
                     rom0_3, romx_3, stg_3);
          end
        end
        n++;
      end
      seen = done_3;
      cyc++;
      @(negedge clk);
    end
    total++;
    if (!seen || n !== 768) begin
      bad++;
      $display("FAIL exp_run got=%0d done=%b want=768 done=1", n, seen);
    end
  endtask

`ifdef R16_TWG_STALL_EN
  task automatic test_stall();
    int cyc, n, first, last, done_at, left;
    bit re[$];
    bit ev;
    exp_t x;
    sb.delete();
    push_run(2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; n = 0; first = -1; last = -1; done_at = -1; left = 0;
    while (done_at < 0 && cyc < 100) begin
      if (en_2) begin
        x = sb.pop_front();
        total++;
        if (rom0_2 !== 2'(x.r0) || romx_2 !== 2'(x.rx) ||
            stg_2 !== 2'(x.st)) begin
          bad++;
          $display("FAIL stall_issue%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   n, rom0_2, romx_2, stg_2, x.r0, x.rx, x.st);
        end
        if (n == 9) left = 5;
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
      ev = (re.size() >= 7) ? re[re.size()-7] : 1'b0;
      total++;
      if (val_2 !== ev) begin
        bad++;
        $display("FAIL stall_valid_c%0d got=%b want=%b", cyc, val_2, ev);
      end
      re.push_back(en_2);
      if (done_2) done_at = cyc;
      stall = (left > 0);
      if (left > 0) left--;
      cyc++;
      @(negedge clk);
    end
    stall = 1'b0;
    total++;
    if (n !== 32 || (last - first + 1) - n !== 5) begin
      bad++;
      $display("FAIL stall_gaps got=%0d/%0d want=32/5",
               n, (last - first + 1) - n);
    end
    total++;
    if (done_at < 0 || done_at - last !== 8) begin
      bad++;
      $display("FAIL stall_done got=%0d want=8", done_at - last);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_and_valid();
    test_back_to_back();
    test_mid_reset();
    test_exponent();
`ifdef R16_TWG_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
